// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - RV32I 5-stage hazard controller: stalls, flushes, forwarding, memory-wait timeout
module pipeline_ctrl #(
   parameter int MAX_MEM_WAIT = 255,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      inst_id,
   input  logic [31:0]      inst_ex,
   input  logic             branch_taken,
   input  logic             icache_stall,
   input  logic             dcache_stall,
   output logic             stall_if,
   output logic             stall_id,
   output logic             bubble_ex,
   output logic             flush_id,
   output logic [1:0]       pc_sel,
   output logic             fwd_rs1,
   output logic             fwd_rs2,
   output logic             fwd_from_mem,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;

   localparam logic [1:0] PC_PLUS4  = 2'b00;
   localparam logic [1:0] PC_TARGET = 2'b01;
   localparam logic [1:0] PC_HOLD   = 2'b10;

   localparam logic [7:0] TO_CNT    = 8'(MAX_MEM_WAIT - 1);

   typedef enum logic [1:0] {S_RUN, S_LDSTALL, S_REDIRECT, S_MEMWAIT} state_t;

   state_t           r_state, w_next;
   logic             r_cap_rs1, r_cap_rs2;
   logic [7:0]       r_wait_cnt;
   logic             r_timeout;
   logic [CNT_W-1:0] r_stall_cycles;

   logic [6:0] w_op_id, w_op_ex;
   logic [4:0] w_rd_ex, w_rs1_id, w_rs2_id;
   logic       w_ex_writes, w_uses_rs1, w_uses_rs2;
   logic       w_match1, w_match2, w_redirect, w_load_use, w_mem_stall, w_run_rules;
   logic       w_capture, w_enter_mw;
   logic       w_stall_if, w_stall_id, w_bubble_ex, w_flush_id, w_fwd_rs1, w_fwd_rs2, w_fwd_mem;
   logic [1:0] w_pc_sel;

   assign w_op_id  = inst_id[6:0];
   assign w_op_ex  = inst_ex[6:0];
   assign w_rd_ex  = inst_ex[11:7];
   assign w_rs1_id = inst_id[19:15];
   assign w_rs2_id = inst_id[24:20];

   assign w_ex_writes = (w_op_ex != OP_STORE) && (w_op_ex != OP_BRANCH) && (w_rd_ex != 5'd0);
   assign w_uses_rs1  = (w_op_id != OP_LUI) && (w_op_id != OP_AUIPC) && (w_op_id != OP_JAL);
   assign w_uses_rs2  = (w_op_id == OP_R) || (w_op_id == OP_STORE) || (w_op_id == OP_BRANCH);
   assign w_match1    = w_ex_writes && w_uses_rs1 && (w_rd_ex == w_rs1_id);
   assign w_match2    = w_ex_writes && w_uses_rs2 && (w_rd_ex == w_rs2_id);
   assign w_redirect  = (w_op_ex == OP_JAL) || (w_op_ex == OP_JALR) ||
                        ((w_op_ex == OP_BRANCH) && branch_taken);
   assign w_load_use  = (w_op_ex == OP_LOAD) && (w_match1 || w_match2);
   assign w_mem_stall = icache_stall || dcache_stall;
   // MEMWAIT hands over to the RUN decision in the cycle both memories become ready
   assign w_run_rules = (r_state == S_RUN) || ((r_state == S_MEMWAIT) && !w_mem_stall);

   always_comb begin
      w_next      = r_state;
      w_capture   = 1'b0;
      w_enter_mw  = 1'b0;
      w_stall_if  = 1'b0;
      w_stall_id  = 1'b0;
      w_bubble_ex = 1'b0;
      w_flush_id  = 1'b0;
      w_pc_sel    = PC_PLUS4;
      w_fwd_rs1   = 1'b0;
      w_fwd_rs2   = 1'b0;
      w_fwd_mem   = 1'b0;
      if (rst) begin
         w_next = S_RUN;
      end else if (w_run_rules) begin
         if (w_mem_stall) begin
            w_stall_if = 1'b1;
            w_stall_id = 1'b1;
            w_pc_sel   = PC_HOLD;
            w_enter_mw = 1'b1;
            w_next     = S_MEMWAIT;
         end else if (w_redirect) begin
            w_pc_sel   = PC_TARGET;
            w_flush_id = 1'b1;
            w_next     = S_REDIRECT;
         end else if (w_load_use) begin
            w_stall_if  = 1'b1;
            w_stall_id  = 1'b1;
            w_bubble_ex = 1'b1;
            w_pc_sel    = PC_HOLD;
            w_capture   = 1'b1;
            w_next      = S_LDSTALL;
         end else begin
            w_fwd_rs1 = w_match1;
            w_fwd_rs2 = w_match2;
            w_next    = S_RUN;
         end
      end else begin
         case (r_state)
            S_REDIRECT: begin
               w_flush_id  = 1'b1;
               w_bubble_ex = 1'b1;
               w_next      = S_RUN;
            end
            S_LDSTALL: begin
               w_fwd_rs1 = r_cap_rs1;
               w_fwd_rs2 = r_cap_rs2;
               w_fwd_mem = 1'b1;
               w_next    = S_RUN;
            end
            default: begin
               w_stall_if = 1'b1;
               w_stall_id = 1'b1;
               w_pc_sel   = PC_HOLD;
               w_next     = S_MEMWAIT;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= S_RUN;
         r_cap_rs1      <= 1'b0;
         r_cap_rs2      <= 1'b0;
         r_wait_cnt     <= 8'd0;
         r_timeout      <= 1'b0;
         r_stall_cycles <= '0;
      end else begin
         r_state <= w_next;
         if (w_capture) begin
            r_cap_rs1 <= w_match1;
            r_cap_rs2 <= w_match2;
         end
         if (w_enter_mw) begin
            r_wait_cnt <= 8'd0;
         end else if ((r_state == S_MEMWAIT) && w_mem_stall) begin
            if (r_wait_cnt != 8'hFF) r_wait_cnt <= r_wait_cnt + 8'd1;
            if (r_wait_cnt >= TO_CNT) r_timeout <= 1'b1;
         end
         if (w_stall_if && (r_stall_cycles != {CNT_W{1'b1}}))
            r_stall_cycles <= r_stall_cycles + 1'b1;
      end
   end

   assign stall_if     = w_stall_if;
   assign stall_id     = w_stall_id;
   assign bubble_ex    = w_bubble_ex;
   assign flush_id     = w_flush_id;
   assign pc_sel       = w_pc_sel;
   assign fwd_rs1      = w_fwd_rs1;
   assign fwd_rs2      = w_fwd_rs2;
   assign fwd_from_mem = w_fwd_mem;
   assign mem_timeout  = r_timeout;
   assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

   localparam logic [31:0] NOP      = 32'h00000013;
   localparam logic [31:0] LW_X5    = 32'h0000A283;
   localparam logic [31:0] ADD_657  = 32'h00728333;
   localparam logic [31:0] BEQ      = 32'h00208063;
   localparam logic [31:0] ADDI_X5  = 32'h00100293;
   localparam logic [31:0] ADD_655  = 32'h00528333;
   localparam logic [31:0] ADDI_X0  = 32'h00100013;
   localparam logic [31:0] ADD_100  = 32'h000000B3;
   localparam logic [31:0] SW_RD6   = 32'h00532323;
   localparam logic [31:0] ADD_766  = 32'h006303B3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] inst_id = NOP;
   logic [31:0] inst_ex = NOP;
   logic        branch_taken = 1'b0;
   logic        icache_stall = 1'b0;
   logic        dcache_stall = 1'b0;
   logic        stall_if, stall_id, bubble_ex, flush_id;
   logic [1:0]  pc_sel;
   logic        fwd_rs1, fwd_rs2, fwd_from_mem, mem_timeout;
   logic [15:0] stall_cycles;

   int total = 0;
   int bad   = 0;

   pipeline_ctrl #(.MAX_MEM_WAIT(4), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .inst_id(inst_id), .inst_ex(inst_ex),
      .branch_taken(branch_taken), .icache_stall(icache_stall), .dcache_stall(dcache_stall),
      .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex), .flush_id(flush_id),
      .pc_sel(pc_sel), .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2), .fwd_from_mem(fwd_from_mem),
      .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input logic [31:0] ex, input logic [31:0] id);
      inst_ex = ex;
      inst_id = id;
      #1;
   endtask

   initial begin
      // reset state
      #3;
      chk("rst_stall_if", stall_if, 0);
      chk("rst_pc_sel", pc_sel, 0);
      chk("rst_stall_cycles", stall_cycles, 0);
      cyc();
      rst = 1'b0;
      drive(NOP, NOP);
      chk("run_pc_sel", pc_sel, 0);
      chk("run_stall_if", stall_if, 0);

      // load-use
      drive(LW_X5, ADD_657);
      chk("lu_stall_if", stall_if, 1);
      chk("lu_stall_id", stall_id, 1);
      chk("lu_bubble", bubble_ex, 1);
      chk("lu_pc_sel", pc_sel, 2'b10);
      cyc();
      drive(NOP, ADD_657);
      chk("ld_fwd_rs1", fwd_rs1, 1);
      chk("ld_fwd_rs2", fwd_rs2, 0);
      chk("ld_fwd_mem", fwd_from_mem, 1);
      chk("ld_stall_if", stall_if, 0);
      chk("ld_stall_cycles", stall_cycles, 1);
      cyc();

      // taken branch, redirect ignored while in REDIRECT
      branch_taken = 1'b1;
      drive(BEQ, NOP);
      chk("br_pc_sel", pc_sel, 2'b01);
      chk("br_flush", flush_id, 1);
      cyc();
      chk("rd_flush", flush_id, 1);
      chk("rd_bubble", bubble_ex, 1);
      chk("rd_pc_sel", pc_sel, 0);
      cyc();
      branch_taken = 1'b0;
      drive(BEQ, NOP);
      chk("nt_pc_sel", pc_sel, 0);
      chk("nt_flush", flush_id, 0);
      chk("nt_bubble", bubble_ex, 0);

      // ALU forwarding and the no-forward cases
      drive(ADDI_X5, ADD_655);
      chk("alu_fwd_rs1", fwd_rs1, 1);
      chk("alu_fwd_rs2", fwd_rs2, 1);
      chk("alu_fwd_mem", fwd_from_mem, 0);
      drive(ADDI_X0, ADD_100);
      chk("x0_fwd_rs1", fwd_rs1, 0);
      chk("x0_fwd_rs2", fwd_rs2, 0);
      drive(SW_RD6, ADD_766);
      chk("sw_fwd_rs1", fwd_rs1, 0);
      chk("sw_fwd_rs2", fwd_rs2, 0);
      chk("sw_stall_if", stall_if, 0);

      // dcache stall masks a load-use pair for 3 cycles
      dcache_stall = 1'b1;
      drive(LW_X5, ADD_657);
      for (int k = 0; k < 3; k++) begin
         chk("ms_stall_if", stall_if, 1);
         chk("ms_bubble", bubble_ex, 0);
         chk("ms_pc_sel", pc_sel, 2'b10);
         chk("ms_fwd_rs1", fwd_rs1, 0);
         cyc();
      end
      dcache_stall = 1'b0;
      #1;
      chk("ms_lu_stall_if", stall_if, 1);
      chk("ms_lu_bubble", bubble_ex, 1);
      chk("ms_stall_cycles", stall_cycles, 4);
      cyc();
      drive(NOP, ADD_657);
      chk("ms_ld_fwd_rs1", fwd_rs1, 1);
      chk("ms_ld_fwd_mem", fwd_from_mem, 1);
      chk("ms_stall_cycles2", stall_cycles, 5);
      chk("ms_no_timeout", mem_timeout, 0);
      cyc();

      // memory-wait timeout with MAX_MEM_WAIT = 4
      icache_stall = 1'b1;
      drive(NOP, NOP);
      for (int k = 1; k <= 9; k++) begin
         cyc();
         chk($sformatf("to_edge%0d", k), mem_timeout, (k >= 5) ? 1 : 0);
      end
      cyc();
      icache_stall = 1'b0;
      #1;
      chk("to_sticky", mem_timeout, 1);
      chk("to_stall_if", stall_if, 0);
      chk("to_stall_cycles", stall_cycles, 15);

      // async reset mid-LDSTALL
      cyc();
      drive(LW_X5, ADD_657);
      cyc();
      chk("pre_rst_fwd_mem", fwd_from_mem, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_fwd_mem", fwd_from_mem, 0);
      chk("arst_fwd_rs1", fwd_rs1, 0);
      chk("arst_stall_if", stall_if, 0);
      chk("arst_pc_sel", pc_sel, 0);
      chk("arst_stall_cycles", stall_cycles, 0);
      chk("arst_timeout", mem_timeout, 0);
      cyc();
      rst = 1'b0;
      #1;
      chk("post_rst_run_stall", stall_if, 1);
      chk("post_rst_fwd_mem", fwd_from_mem, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter MAX_MEM_WAIT, default 255, memory-wait cycle count at which mem_timeout is raised (range 1..255).
REQ-002 Parameter CNT_W, default 16, width of stall_cycles.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 inst_id  input  32  instruction in decode stage.
REQ-006 inst_ex  input  32  instruction in execute stage.
REQ-007 branch_taken  input  1  SB-type inst_ex condition true.
REQ-008 icache_stall  input  1  instruction memory not ready.
REQ-009 dcache_stall  input  1  data memory not ready.
REQ-010 stall_if  output  1  hold PC and IF register.
REQ-011 stall_id  output  1  hold ID register.
REQ-012 bubble_ex  output  1  load NOP into EX at next edge.
REQ-013 flush_id  output  1  replace ID contents with NOP at next edge.
REQ-014 pc_sel  output  2  00 PC+4, 01 EX branch/jump target, 10 hold.
REQ-015 fwd_rs1, fwd_rs2  output  1 each  forward into ID operand.
REQ-016 fwd_from_mem  output  1  forward source is load data (1) or ALU result (0).
REQ-017 mem_timeout  output  1  sticky memory-wait timeout flag.
REQ-018 stall_cycles  output  CNT_W  saturating count of stall_if cycles.

Function
REQ-019 Decode: opcode [6:0], rd [11:7], rs1 [19:15], rs2 [24:20]; RISC-V RV32I opcodes.
REQ-020 inst_ex writes rd unless opcode is STORE (0100011) or BRANCH (1100011), and never when rd = 0.
REQ-021 inst_id uses rs1 unless LUI, AUIPC, or JAL; it uses rs2 only for R-type, STORE, or BRANCH.
REQ-022 redirect = inst_ex is JAL or JALR, or inst_ex is BRANCH with branch_taken = 1.
REQ-023 load_use = inst_ex is LOAD (0000011), writes rd, and rd matches a used source of inst_id.
REQ-024 FSM states: RUN, LDSTALL, REDIRECT, MEMWAIT; registered state; all outputs are combinational from state, registers, and inputs.
REQ-025 In RUN, priority is mem stall (icache_stall | dcache_stall) > redirect > load_use > normal.
REQ-026 RUN with mem stall: stall_if = stall_id = bubble_ex = 0 except stall_if = stall_id = 1, pc_sel = 10; next state is MEMWAIT; redirect and load_use are not acted on until the stall ends.
REQ-027 RUN with redirect: pc_sel = 01, flush_id = 1; next state is REDIRECT.
REQ-028 REDIRECT: flush_id = 1, bubble_ex = 1, pc_sel = 00; the wrong-path instruction is squashed; next state is RUN; a redirect input in this state is ignored.
REQ-029 RUN with load_use: stall_if = stall_id = 1, bubble_ex = 1, pc_sel = 10; the rs1/rs2 match flags are captured; next state is LDSTALL.
REQ-030 LDSTALL: stall outputs = 0, pc_sel = 00; fwd_rs1/fwd_rs2 equal the captured flags; fwd_from_mem = 1; next state is RUN.
REQ-031 Normal RUN: pc_sel = 00; fwd_rsN = 1 when inst_ex writes rd and rd matches a used source of inst_id; fwd_from_mem = 0.
REQ-032 MEMWAIT: stall_if = stall_id = 1, bubble_ex = 0, pc_sel = 10, and no forwards.
REQ-033 MEMWAIT exits to RUN in the first cycle both memory stalls are 0; in that cycle, outputs follow RUN rules for the current inputs.
REQ-034 MEMWAIT keeps an 8-bit wait counter that is cleared on entry; mem_timeout is set when the counter reaches MAX_MEM_WAIT and stays set until rst.
REQ-035 stall_cycles increments on every clock edge where stall_if = 1, and holds at all-ones.
REQ-036 In any state other than RUN, flush_id = 0 unless stated otherwise; pc_sel = 10 is never combined with flush_id = 1.

Reset
REQ-037 rst asserted at any time forces state = RUN, the captured flags = 0, the wait counter = 0, mem_timeout = 0, and stall_cycles = 0, immediately and without a clock.
REQ-038 During rst, all outputs are 0 (pc_sel = 00).
REQ-039 The first edge after rst deasserts evaluates RUN rules.

Verification
REQ-040 inst_ex = lw x5, inst_id = add x6,x5,x7 -> 1 cycle with stall_if = stall_id = bubble_ex = 1; next cycle fwd_rs1 = 1, fwd_from_mem = 1, fwd_rs2 = 0; stall_cycles = 1.
REQ-041 inst_ex = beq with branch_taken = 1 -> pc_sel = 01, flush_id = 1; next cycle flush_id = 1, bubble_ex = 1, pc_sel = 00; with branch_taken = 0 -> no action.
REQ-042 dcache_stall = 1 for 3 cycles simultaneously with a load_use pair -> stall_if = 1 for 3 cycles and bubble_ex = 0; then the load-use stall; stall_cycles = 4.
REQ-043 MAX_MEM_WAIT = 4, icache_stall held for 10 cycles -> mem_timeout rises after the 4th MEMWAIT edge and stays 1 after the stall clears.
REQ-044 inst_ex = addi x0,x0,1, inst_id = add x1,x0,x0 -> no forwarding; inst_ex = sw, inst_id using matching fields -> no forwarding.
REQ-045 rst pulsed mid-LDSTALL, unaligned to clk -> outputs are 0 immediately and stall_cycles = 0.
